// File: rtl/date_pkg.sv
// Shared types and constants for the date sequencer: FSM states, month range,
// reset lookup address and month lengths.
package date_pkg;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      ADV,
      CAPT,
      SETCHK
   } state_t;

   localparam int MONTH_MIN     = 1;
   localparam int MONTH_MAX     = 12;
   localparam int MONTH_FEB     = 2;
   localparam int RESET_ADDR    = 'h041;
   localparam int DAYS_LONG     = 31;
   localparam int DAYS_SHORT    = 30;
   localparam int DAYS_FEB      = 28;
   localparam int DAYS_FEB_LEAP = 29;

endpackage

// File: rtl/days_in_month.sv
// Month length lookup, shared by the day-advance and set-validation paths.
module days_in_month
   import date_pkg::*;
#(
   parameter int FIELD_W = 6
) (
   input  logic [FIELD_W-1:0] month,
   input  logic               leap,
   output logic [FIELD_W-1:0] days
);

   always_comb begin
      days = FIELD_W'(DAYS_LONG);
      case (int'(month))
         MONTH_FEB:    days = leap ? FIELD_W'(DAYS_FEB_LEAP) : FIELD_W'(DAYS_FEB);
         4, 6, 9, 11:  days = FIELD_W'(DAYS_SHORT);
         default:      ;
      endcase
   end

endmodule

// File: rtl/date_seq_ctrl.sv
// Calendar date sequencer driving an external lookup table and latching its
// results. Optional leap-year support is enabled with `define LEAP_YEAR_EN.
module date_seq_ctrl
   import date_pkg::*;
#(
   parameter int FIELD_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 day_tick,
   input  logic                 set_req,
   input  logic [FIELD_W-1:0]   set_month,
   input  logic [FIELD_W-1:0]   set_day,
`ifdef LEAP_YEAR_EN
   input  logic [1:0]           set_leap_phase,
`endif
   output logic                 set_ack,
   output logic                 set_err,
   output logic [2*FIELD_W-1:0] rom_address,
   input  logic [7:0]           rom_data_month,
   input  logic [7:0]           rom_data_day,
   output logic [7:0]           disp_month,
   output logic [7:0]           disp_day,
   output logic                 disp_valid,
   output logic                 year_end
);

   state_t             state_reg;
   logic [FIELD_W-1:0] month_reg;
   logic [FIELD_W-1:0] day_reg;
   logic               pend_reg;
   logic               armed_reg;

   logic [FIELD_W-1:0] chk_month;
   logic               chk_leap;
   logic [FIELD_W-1:0] dim;
   logic               set_ok;
   logic [FIELD_W-1:0] adv_month;
   logic [FIELD_W-1:0] adv_day;
   logic               adv_wrap;

`ifdef LEAP_YEAR_EN
   logic [1:0]         year_reg;

   // Set validation judges Feb 29 against the requested phase, not the current one.
   assign chk_leap = (state_reg == SETCHK) ? (set_leap_phase == 2'd0) : (year_reg == 2'd0);
`else
   assign chk_leap = 1'b0;
`endif

   assign chk_month = (state_reg == SETCHK) ? set_month : month_reg;

   days_in_month #(.FIELD_W(FIELD_W)) u_dim (
      .month (chk_month),
      .leap  (chk_leap),
      .days  (dim)
   );

   assign set_ok = (set_month >= FIELD_W'(MONTH_MIN)) && (set_month <= FIELD_W'(MONTH_MAX)) &&
                   (set_day != '0) && (set_day <= dim);

   always_comb begin
      adv_month = month_reg;
      adv_day   = day_reg + FIELD_W'(1);
      adv_wrap  = 1'b0;
      if (day_reg >= dim) begin
         adv_day = FIELD_W'(1);
         if (month_reg == FIELD_W'(MONTH_MAX)) begin
            adv_month = FIELD_W'(MONTH_MIN);
            adv_wrap  = 1'b1;
         end else begin
            adv_month = month_reg + FIELD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= INIT;
         month_reg   <= FIELD_W'(MONTH_MIN);
         day_reg     <= FIELD_W'(1);
         rom_address <= (2*FIELD_W)'(RESET_ADDR);
         pend_reg    <= 1'b0;
         armed_reg   <= 1'b1;
         disp_month  <= 8'd0;
         disp_day    <= 8'd0;
         disp_valid  <= 1'b0;
         set_ack     <= 1'b0;
         set_err     <= 1'b0;
         year_end    <= 1'b0;
`ifdef LEAP_YEAR_EN
         year_reg    <= 2'd0;
`endif
      end else begin
         set_ack  <= 1'b0;
         set_err  <= 1'b0;
         year_end <= 1'b0;
         if (!set_req)
            armed_reg <= 1'b1;
         // One-deep memory for ticks that arrive while busy.
         if (day_tick && state_reg != IDLE)
            pend_reg <= 1'b1;

         case (state_reg)
            INIT: state_reg <= CAPT;
            IDLE: begin
               if (set_req && armed_reg) begin
                  state_reg  <= SETCHK;
                  disp_valid <= 1'b0;
               end else if (day_tick || pend_reg) begin
                  state_reg  <= ADV;
                  pend_reg   <= 1'b0;
                  disp_valid <= 1'b0;
               end
            end
            ADV: begin
               month_reg   <= adv_month;
               day_reg     <= adv_day;
               rom_address <= {adv_month, adv_day};
               year_end    <= adv_wrap;
`ifdef LEAP_YEAR_EN
               if (adv_wrap)
                  year_reg <= year_reg + 2'd1;
`endif
               state_reg   <= CAPT;
            end
            SETCHK: begin
               set_ack   <= 1'b1;
               set_err   <= !set_ok;
               armed_reg <= 1'b0;
               if (set_ok) begin
                  month_reg   <= set_month;
                  day_reg     <= set_day;
                  rom_address <= {set_month, set_day};
`ifdef LEAP_YEAR_EN
                  year_reg    <= set_leap_phase;
`endif
                  state_reg   <= CAPT;
               end else begin
                  // Date untouched, so the latched display is still current.
                  disp_valid <= 1'b1;
                  state_reg  <= IDLE;
               end
            end
            CAPT: begin
               disp_month <= rom_data_month;
               disp_day   <= rom_data_day;
               disp_valid <= 1'b1;
               state_reg  <= IDLE;
            end
            default: state_reg <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_date_seq_ctrl.sv
// Randomized self-checking bench for date_seq_ctrl against a calendar model;
// honours LEAP_YEAR_EN when defined.
module tb_date_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        day_tick = 1'b0;
   logic        set_req = 1'b0;
   logic [5:0]  set_month = '0;
   logic [5:0]  set_day = '0;
`ifdef LEAP_YEAR_EN
   logic [1:0]  set_leap_phase = '0;
`endif
   logic        set_ack, set_err, disp_valid, year_end;
   logic [11:0] rom_address;
   logic [7:0]  rom_data_month, rom_data_day, disp_month, disp_day;

   int tests_run = 0;
   int tests_failed = 0;

   int m_month = 1;
   int m_day = 1;
   int m_phase = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] lut_m(logic [11:0] a);
      return {2'b00, a[11:6]} ^ 8'h5A;
   endfunction

   function automatic logic [7:0] lut_d(logic [11:0] a);
      return a[7:0] + 8'h3C;
   endfunction

   assign rom_data_month = lut_m(rom_address);
   assign rom_data_day   = lut_d(rom_address);

   date_seq_ctrl #(.FIELD_W(6)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .day_tick       (day_tick),
      .set_req        (set_req),
      .set_month      (set_month),
      .set_day        (set_day),
`ifdef LEAP_YEAR_EN
      .set_leap_phase (set_leap_phase),
`endif
      .set_ack        (set_ack),
      .set_err        (set_err),
      .rom_address    (rom_address),
      .rom_data_month (rom_data_month),
      .rom_data_day   (rom_data_day),
      .disp_month     (disp_month),
      .disp_day       (disp_day),
      .disp_valid     (disp_valid),
      .year_end       (year_end)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int m_dim(input int m, input int phase);
      bit leap;
`ifdef LEAP_YEAR_EN
      leap = (phase == 0);
`else
      leap = (phase < 0);
`endif
      if (m == 2) return leap ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic logic [11:0] m_addr();
      return 12'(m_month * 64 + m_day);
   endfunction

   task automatic m_advance(output int ye);
      ye = 0;
      if (m_day < m_dim(m_month, m_phase)) m_day++;
      else begin
         m_day = 1;
         if (m_month == 12) begin
            m_month = 1;
            ye = 1;
            m_phase = (m_phase + 1) % 4;
         end else m_month++;
      end
   endtask

   task automatic check_disp(input string tag);
      check_eq({tag, "_valid"}, disp_valid, 1);
      check_eq({tag, "_dmonth"}, disp_month, lut_m(m_addr()));
      check_eq({tag, "_dday"}, disp_day, lut_d(m_addr()));
   endtask

   task automatic do_tick();
      logic [11:0] old_addr;
      int ye;
      old_addr = m_addr();
      m_advance(ye);
      day_tick = 1'b1;
      cyc();
      day_tick = 1'b0;
      check_eq("tick_dv_adv", disp_valid, 0);
      check_eq("tick_addr_old", rom_address, old_addr);
      cyc();
      check_eq("tick_addr_new", rom_address, m_addr());
      check_eq("tick_dv_capt", disp_valid, 0);
      check_eq("tick_year_end", year_end, ye);
      cyc();
      check_disp("tick_done");
      check_eq("tick_year_end_off", year_end, 0);
      $display("[TB] tick -> %0d/%0d year_end=%0d", m_month, m_day, ye);
   endtask

   task automatic do_set(input int mo, input int dy, input int ph, input bit with_tick, input int hold);
      bit valid, got;
      valid = (mo >= 1) && (mo <= 12) && (dy >= 1) && (dy <= m_dim(mo, ph));
      set_req = 1'b1;
      set_month = 6'(mo);
      set_day = 6'(dy);
`ifdef LEAP_YEAR_EN
      set_leap_phase = 2'(ph);
`endif
      day_tick = with_tick;
      cyc();
      day_tick = 1'b0;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         if (set_ack === 1'b1) got = 1;
         else cyc();
      end
      check_eq("set_ack_seen", got, 1);
      if (valid) begin
         m_month = mo;
         m_day = dy;
         m_phase = ph;
      end
      check_eq("set_err", set_err, !valid);
      check_eq("set_addr", rom_address, m_addr());
      for (int i = 0; i < hold; i++) begin
         cyc();
         check_eq("set_no_reack", set_ack, 0);
      end
      set_req = 1'b0;
      cyc();
      check_eq("set_ack_off", set_ack, 0);
      check_disp("set_done");
      if (with_tick) begin
         cyc(); cyc(); cyc();
         check_eq("set_tick_lost", rom_address, m_addr());
      end
      $display("[TB] set %0d/%0d ph=%0d tick=%0d hold=%0d err=%0d -> %0d/%0d",
               mo, dy, ph, with_tick, hold, !valid, m_month, m_day);
   endtask

   task automatic do_double_tick();
      int ye;
      m_advance(ye);
      m_advance(ye);
      day_tick = 1'b1;
      cyc();
      cyc();
      cyc();
      day_tick = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      check_eq("dtick_addr", rom_address, m_addr());
      check_disp("dtick_done");
      $display("[TB] busy ticks -> %0d/%0d", m_month, m_day);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_addr"}, rom_address, 12'h041);
      check_eq({tag, "_dv"}, disp_valid, 0);
      check_eq({tag, "_dmonth"}, disp_month, 0);
      check_eq({tag, "_dday"}, disp_day, 0);
      check_eq({tag, "_ack"}, set_ack, 0);
      check_eq({tag, "_err"}, set_err, 0);
      check_eq({tag, "_ye"}, year_end, 0);
   endtask

   task automatic release_reset(input string tag);
      m_month = 1;
      m_day = 1;
      m_phase = 0;
      rst_n = 1'b1;
      cyc();
      check_eq({tag, "_dv_c1"}, disp_valid, 0);
      check_eq({tag, "_addr_c1"}, rom_address, 12'h041);
      cyc();
      check_disp({tag, "_c2"});
      $display("[TB] reset release %s", tag);
   endtask

   initial begin
      int mo, dy, ph, d, kind;
      cyc(); cyc();
      check_reset_vals("rst");
      release_reset("por");

      do_set(1, 31, 1, 1'b0, 0);
      do_tick();
      check_eq("jan31_to_feb1", rom_address, 12'h081);
      do_set(12, 31, 1, 1'b0, 0);
      do_tick();
      check_eq("dec31_to_jan1", rom_address, 12'h041);
      do_set(2, 30, 0, 1'b0, 0);
      do_set(13, 1, 0, 1'b0, 2);
      do_set(2, 28, 0, 1'b0, 0);
      do_tick();
`ifdef LEAP_YEAR_EN
      check_eq("feb28_to_feb29", rom_address, 12'h09D);
      do_tick();
`endif
      check_eq("feb_to_mar1", rom_address, 12'h0C1);
      do_set(5, 10, 1, 1'b1, 0);
      do_double_tick();

      // Asynchronous reset in the middle of an advance.
      day_tick = 1'b1;
      cyc();
      day_tick = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      cyc(); cyc();
      release_reset("mid");
      for (int i = 0; i < 4; i++) cyc();
      check_eq("mid_rst_no_pend", rom_address, 12'h041);

      for (int t = 0; t < 200; t++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 4) do_tick();
         else if (kind == 9) do_double_tick();
         else begin
            mo = $urandom_range(0, 13);
            ph = $urandom_range(0, 3);
            d = (mo >= 1 && mo <= 12) ? m_dim(mo, ph) : 31;
            case ($urandom_range(0, 2))
               0: dy = d - 1 + $urandom_range(0, 2);
               1: dy = $urandom_range(0, 33);
               default: dy = $urandom_range(1, 28);
            endcase
            do_set(mo, dy, ph, kind == 8, $urandom_range(0, 2));
         end
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
